// File: rtl/capture_trigger_controller_if.sv
// Host/detector/sample-RAM signal bundle for the capture trigger controller.
// The master side drives commands and the detector input; the slave side is the controller.
interface capture_trigger_controller_if #(
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 16
);
  logic              arm;
  logic              abort;
  logic [ADDR_W-1:0] pre_count;
  logic [ADDR_W-1:0] post_count;
  logic [DIV_W-1:0]  div;
  logic              change;
  logic              inh;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              busy;
  logic              done;

  modport master (
    output arm, abort, pre_count, post_count, div, change,
    input  inh, wr_en, wr_addr, trig_addr, busy, done
  );

  modport slave (
    input  arm, abort, pre_count, post_count, div, change,
    output inh, wr_en, wr_addr, trig_addr, busy, done
  );
endinterface

// File: rtl/capture_trigger_controller.sv
// Sequences one logic-analyzer capture: pre-trigger fill, armed circular writes,
// trigger address capture and a fixed post-trigger window. All outputs registered.
module capture_trigger_controller #(
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  capture_trigger_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [DIV_W-1:0]  ONE_D = DIV_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pre_q, post_q;
  logic [DIV_W-1:0]  div_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic [DIV_W-1:0]  presc_q, presc_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              inh_q, busy_q;
  logic              load, strobe, active_q, active_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = wr_en_q ? cnt_q + ONE_A : cnt_q;
    wr_addr_d = wr_en_q ? wr_addr_q + ONE_A : wr_addr_q;
    trig_d    = trig_q;
    done_d    = done_q;
    presc_d   = presc_q;
    load      = 1'b0;
    strobe    = (presc_q == div_q);
    active_q  = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);

    case (state_q)
      IDLE, DONE: begin
        if (bus.arm && !bus.abort) begin
          state_d   = PRE;
          load      = 1'b1;
          done_d    = 1'b0;
          wr_addr_d = '0;
          cnt_d     = '0;
          presc_d   = '0;
        end
      end
      PRE: begin
        if (pre_q == '0 || (wr_en_q && (cnt_q + ONE_A) == pre_q)) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        // The trigger sample is the one being written this cycle.
        if (wr_en_q && bus.change) begin
          trig_d  = wr_addr_q;
          cnt_d   = '0;
          state_d = (post_q == '0) ? DONE : POST;
        end
      end
      POST: begin
        if (post_q == '0 || (wr_en_q && (cnt_q + ONE_A) == post_q))
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (active_q) begin
      presc_d = strobe ? '0 : presc_q + ONE_D;
      if (bus.abort) state_d = IDLE;
    end

    active_d = (state_d == PRE) || (state_d == ARMED) || (state_d == POST);
    // Strobes only fire while staying inside the capture; leaving suppresses the next write.
    wr_en_d  = active_q && active_d && strobe;
    if (state_d == DONE && state_q != DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      trig_q    <= '0;
      presc_q   <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      inh_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      trig_q    <= trig_d;
      presc_q   <= presc_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      inh_q     <= (state_d != ARMED);
      busy_q    <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pre_q  <= bus.pre_count;
      post_q <= bus.post_count;
      div_q  <= bus.div;
    end
  end

  assign bus.inh       = inh_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.trig_addr = trig_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_capture_trigger_controller.sv
// Directed bench for capture_trigger_controller: one task per scenario with inline checks,
// a 10-bit-address instance for most scenarios and a 3-bit one for wrap-around.
module tb_capture_trigger_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  capture_trigger_controller_if #(.ADDR_W(10), .DIV_W(16)) bus ();
  capture_trigger_controller_if #(.ADDR_W(3),  .DIV_W(16)) bus3 ();

  capture_trigger_controller #(.ADDR_W(10), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  capture_trigger_controller #(.ADDR_W(3), .DIV_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.arm = 0; bus.abort = 0; bus.change = 0; bus.pre_count = '0; bus.post_count = '0; bus.div = '0;
    bus3.arm = 0; bus3.abort = 0; bus3.change = 0; bus3.pre_count = '0; bus3.post_count = '0; bus3.div = '0;
    repeat (2) step();
    checks++; if (bus.inh !== 1'b1) begin errors++; $display("FAIL reset_inh got=%0d want=1", bus.inh); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0d want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0d want=0", bus.done); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0d want=0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 10'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d want=0", bus.wr_addr); end
    checks++; if (bus.trig_addr !== 10'd0) begin errors++; $display("FAIL reset_trig_addr got=%0d want=0", bus.trig_addr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int   addrs[$];
    logic inhs[$];
    int   armed = 0, last_wr = -1, done_cyc = -1, n;
    bus.div = 16'd0; bus.pre_count = 10'd4; bus.post_count = 10'd3;
    bus.arm = 1; step(); bus.arm = 0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_arm got=%0d want=1", bus.busy); end
    for (int c = 1; c <= 40; c++) begin
      step();
      bus.change = 0;
      if (bus.done === 1'b1) begin done_cyc = c; break; end
      if (bus.wr_en === 1'b1) begin
        addrs.push_back(int'(bus.wr_addr));
        inhs.push_back(bus.inh);
        last_wr = c;
        if (bus.inh === 1'b0) begin armed++; bus.change = (armed == 3); end
      end
    end
    bus.change = 0;
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL basic_done_timeout got=none want=done"); end
    checks++; if (done_cyc != last_wr + 1) begin errors++; $display("FAIL basic_done_timing got=cycle%0d want=cycle%0d", done_cyc, last_wr + 1); end
    checks++; if (addrs.size() != 10) begin errors++; $display("FAIL basic_write_count got=%0d want=10", addrs.size()); end
    n = (addrs.size() < 10) ? addrs.size() : 10;
    for (int i = 0; i < n; i++) begin
      checks++; if (addrs[i] != i) begin errors++; $display("FAIL basic_addr[%0d] got=%0d want=%0d", i, addrs[i], i); end
      checks++; if (inhs[i] !== ((i >= 4 && i <= 6) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL basic_inh[%0d] got=%0d want=%0d", i, inhs[i], (i >= 4 && i <= 6) ? 0 : 1);
      end
    end
    checks++; if (bus.trig_addr !== 10'd6) begin errors++; $display("FAIL basic_trig_addr got=%0d want=6", bus.trig_addr); end
    checks++; if (bus.busy !== 1'b0 || bus.inh !== 1'b1) begin errors++; $display("FAIL basic_done_state got=busy%0d_inh%0d want=busy0_inh1", bus.busy, bus.inh); end
  endtask

  task automatic test_divider();
    bus.div = 16'd2; bus.pre_count = 10'd2; bus.post_count = 10'd0; bus.change = 0;
    bus.arm = 1; step(); bus.arm = 0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL div_done_cleared got=%0d want=0", bus.done); end
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++; if (bus.wr_en !== ((k % 3) == 0)) begin errors++; $display("FAIL div_wr_en[k=%0d] got=%0d want=%0d", k, bus.wr_en, (k % 3) == 0); end
      checks++; if (bus.inh !== (k < 7)) begin errors++; $display("FAIL div_inh[k=%0d] got=%0d want=%0d", k, bus.inh, k < 7); end
    end
    bus.abort = 1; step(); bus.abort = 0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0d want=0", bus.busy); end
    checks++; if (bus.inh !== 1'b1) begin errors++; $display("FAIL abort_inh got=%0d want=1", bus.inh); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%0d want=0", bus.done); end
    checks++; if (bus.trig_addr !== 10'd6) begin errors++; $display("FAIL abort_trig_kept got=%0d want=6", bus.trig_addr); end
    step();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL abort_no_write got=%0d want=0", bus.wr_en); end
  endtask

  task automatic test_collision();
    bus.div = 16'd0; bus.pre_count = 10'd4; bus.post_count = 10'd3;
    bus.arm = 1; bus.abort = 1; step(); bus.arm = 0; bus.abort = 0;
    checks++; if (bus.busy !== 1'b0 || bus.inh !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL collide_idle got=busy%0d_inh%0d_done%0d want=busy0_inh1_done0", bus.busy, bus.inh, bus.done);
    end
    repeat (3) step();
    checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL collide_no_start got=wr%0d_busy%0d want=wr0_busy0", bus.wr_en, bus.busy); end
    bus.arm = 1; step(); bus.arm = 0;
    repeat (3) step();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 10'd2) begin errors++; $display("FAIL busy_arm_pre got=wr%0d_addr%0d want=wr1_addr2", bus.wr_en, bus.wr_addr); end
    bus.arm = 1; step(); bus.arm = 0;
    checks++; if (bus.wr_addr !== 10'd3 || bus.busy !== 1'b1) begin errors++; $display("FAIL busy_arm_ignored got=addr%0d_busy%0d want=addr3_busy1", bus.wr_addr, bus.busy); end
    bus.abort = 1; step(); bus.abort = 0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL collide_cleanup got=%0d want=0", bus.busy); end
  endtask

  task automatic test_zero_windows();
    int nw = 0, first_addr = -1, extra = 0;
    bit done_seen = 0;
    bus.div = 16'd0; bus.pre_count = 10'd0; bus.post_count = 10'd0;
    bus.arm = 1; step(); bus.arm = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      bus.change = 0;
      if (bus.done === 1'b1) begin done_seen = 1; break; end
      if (bus.wr_en === 1'b1) begin
        nw++;
        if (first_addr < 0) first_addr = int'(bus.wr_addr);
        if (bus.inh === 1'b0) bus.change = 1;
      end
    end
    bus.change = 0;
    checks++; if (!done_seen) begin errors++; $display("FAIL zero_done got=0 want=1"); end
    checks++; if (nw != 1) begin errors++; $display("FAIL zero_write_count got=%0d want=1", nw); end
    checks++; if (first_addr != 0) begin errors++; $display("FAIL zero_addr got=%0d want=0", first_addr); end
    checks++; if (bus.trig_addr !== 10'd0) begin errors++; $display("FAIL zero_trig_addr got=%0d want=0", bus.trig_addr); end
    repeat (3) begin step(); if (bus.wr_en === 1'b1) extra++; end
    checks++; if (extra != 0 || bus.done !== 1'b1) begin errors++; $display("FAIL zero_done_hold got=extra%0d_done%0d want=extra0_done1", extra, bus.done); end
  endtask

  task automatic test_wrap();
    int  armed = 0, nw = 0, prev = -1;
    bit  wrapped = 0, done_seen = 0;
    bus3.div = 16'd0; bus3.pre_count = 3'd2; bus3.post_count = 3'd1;
    bus3.arm = 1; step(); bus3.arm = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      bus3.change = 0;
      if (bus3.done === 1'b1) begin done_seen = 1; break; end
      if (bus3.wr_en === 1'b1) begin
        nw++;
        if (prev == 7 && bus3.wr_addr == 3'd0) wrapped = 1;
        prev = int'(bus3.wr_addr);
        if (bus3.inh === 1'b0) begin armed++; bus3.change = (armed == 11); end
      end
    end
    bus3.change = 0;
    checks++; if (!done_seen) begin errors++; $display("FAIL wrap_done got=0 want=1"); end
    checks++; if (!wrapped) begin errors++; $display("FAIL wrap_7_to_0 got=0 want=1"); end
    checks++; if (bus3.trig_addr !== 3'd4) begin errors++; $display("FAIL wrap_trig_addr got=%0d want=4", bus3.trig_addr); end
    checks++; if (nw != 14) begin errors++; $display("FAIL wrap_write_count got=%0d want=14", nw); end
  endtask

  task automatic test_async_reset();
    bit trig = 0;
    bus.div = 16'd0; bus.pre_count = 10'd1; bus.post_count = 10'd5;
    bus.arm = 1; step(); bus.arm = 0;
    for (int c = 1; c <= 20 && !trig; c++) begin
      step();
      if (bus.wr_en === 1'b1 && bus.inh === 1'b0) begin bus.change = 1; trig = 1; end
    end
    step(); bus.change = 0;
    step();
    checks++; if (!trig || bus.busy !== 1'b1 || bus.inh !== 1'b1) begin
      errors++; $display("FAIL areset_in_post got=trig%0d_busy%0d_inh%0d want=trig1_busy1_inh1", trig, bus.busy, bus.inh);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.inh !== 1'b1) begin errors++; $display("FAIL areset_inh got=%0d want=1", bus.inh); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%0d want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL areset_done got=%0d want=0", bus.done); end
    checks++; if (bus.wr_addr !== 10'd0) begin errors++; $display("FAIL areset_wr_addr got=%0d want=0", bus.wr_addr); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL areset_wr_en got=%0d want=0", bus.wr_en); end
    step(); rst_n = 1'b1;
    repeat (2) step();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL areset_stays_idle got=busy%0d_done%0d want=busy0_done0", bus.busy, bus.done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_collision();
    test_zero_windows();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
